// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types for the IFU/LSU memory port arbiter
package mem_arb_pkg;

  localparam int CPU_WIDTH = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } owner_e;

  typedef struct packed {
    logic                 we;
    logic [CPU_WIDTH-1:0] addr;
    logic [CPU_WIDTH-1:0] wdata;
    logic [7:0]           wmask;
  } req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-side signals of the arbiter
interface mem_arbiter_if #(
  parameter int CPU_WIDTH = 64
);

  logic                 i_if_req;
  logic [CPU_WIDTH-1:0] i_if_addr;
  logic                 o_if_gnt;
  logic                 o_if_rvalid;
  logic [31:0]          o_if_rdata;

  logic                 i_ls_req;
  logic                 i_ls_we;
  logic [CPU_WIDTH-1:0] i_ls_addr;
  logic [CPU_WIDTH-1:0] i_ls_wdata;
  logic [7:0]           i_ls_wmask;
  logic                 o_ls_gnt;
  logic                 o_ls_rvalid;
  logic [CPU_WIDTH-1:0] o_ls_rdata;

  logic                 o_mem_req;
  logic                 o_mem_we;
  logic [CPU_WIDTH-1:0] o_mem_addr;
  logic [CPU_WIDTH-1:0] o_mem_wdata;
  logic [7:0]           o_mem_wmask;
  logic                 i_mem_gnt;
  logic                 i_mem_rvalid;
  logic [CPU_WIDTH-1:0] i_mem_rdata;

  // Arbiter view: signal prefixes are relative to the arbiter itself.
  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_wmask,
    output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_wmask,
    input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// rtl/mem_arbiter_arb_pick.sv - LSU-over-IFU winner selection with fetch starvation guard
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_accept,
  input  logic   i_if_req,
  input  logic   i_ls_req,
  output owner_e o_winner
);

  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    o_winner = OWN_NONE;
    if (i_if_req && i_ls_req) begin
      o_winner = (starve_cnt_q == CNT_MAX) ? OWN_IFU : OWN_LSU;
    end else if (i_if_req) begin
      o_winner = OWN_IFU;
    end else if (i_ls_req) begin
      o_winner = OWN_LSU;
    end
  end

  // Only LSU wins that leave a waiting fetch behind count toward starvation.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (i_accept) begin
      if (o_winner == OWN_IFU) begin
        starve_cnt_d = '0;
      end else if (o_winner == OWN_LSU && i_if_req && starve_cnt_q != CNT_MAX) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between instruction fetch and load/store
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int CPU_WIDTH  = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mem_arbiter_if.slave  bus
);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  req_t   req_q, req_d;
  logic   mem_req_q, mem_req_d;

  owner_e winner;
  logic   accept;
  logic   if_rvalid, ls_rvalid;

  arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_accept (accept),
    .i_if_req (bus.i_if_req),
    .i_ls_req (bus.i_ls_req),
    .o_winner (winner)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    req_d     = req_q;
    mem_req_d = mem_req_q;
    accept    = 1'b0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        accept = 1'b1;
      end
      ST_REQ: begin
        // A response seen together with the grant is not ours yet; WAIT owns rvalid.
        if (bus.i_mem_gnt) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (bus.i_mem_rvalid) begin
          accept    = 1'b1;
          if_rvalid = (owner_q == OWN_IFU);
          ls_rvalid = (owner_q == OWN_LSU);
          state_d   = ST_IDLE;
          owner_d   = OWN_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept && winner != OWN_NONE) begin
      state_d   = ST_REQ;
      owner_d   = winner;
      mem_req_d = 1'b1;
      if (winner == OWN_IFU) begin
        req_d.we    = 1'b0;
        req_d.addr  = bus.i_if_addr;
        req_d.wdata = '0;
        req_d.wmask = 8'h00;
      end else begin
        req_d.we    = bus.i_ls_we;
        req_d.addr  = bus.i_ls_addr;
        req_d.wdata = bus.i_ls_wdata;
        req_d.wmask = bus.i_ls_wmask;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_NONE;
      req_q     <= '0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      req_q     <= req_d;
      mem_req_q <= mem_req_d;
    end
  end

  // Combinational pulses are masked by reset so every output reads 0 while held in reset.
  assign bus.o_if_gnt    = i_rst_n && accept && (winner == OWN_IFU);
  assign bus.o_ls_gnt    = i_rst_n && accept && (winner == OWN_LSU);
  assign bus.o_if_rvalid = i_rst_n && if_rvalid;
  assign bus.o_ls_rvalid = i_rst_n && ls_rvalid;
  assign bus.o_if_rdata  = {32{bus.o_if_rvalid}} & bus.i_mem_rdata[31:0];
  assign bus.o_ls_rdata  = {CPU_WIDTH{bus.o_ls_rvalid}} & bus.i_mem_rdata;

  assign bus.o_mem_req   = mem_req_q;
  assign bus.o_mem_we    = req_q.we;
  assign bus.o_mem_addr  = req_q.addr;
  assign bus.o_mem_wdata = req_q.wdata;
  assign bus.o_mem_wmask = req_q.wmask;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [9:0] lsu_pat = 10'b0111101111;

  mem_arbiter_if #(.CPU_WIDTH(64)) bus ();

  mem_arbiter #(
    .CPU_WIDTH  (64),
    .STARVE_MAX (4)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    bus.i_if_req = 1'b0;
    bus.i_if_addr = '0;
    bus.i_ls_req = 1'b0;
    bus.i_ls_we = 1'b0;
    bus.i_ls_addr = '0;
    bus.i_ls_wdata = '0;
    bus.i_ls_wmask = '0;
    bus.i_mem_gnt = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata = '0;

    repeat (2) @(posedge clk);
    #3;
    chk("rst_mem_req", bus.o_mem_req, 0);
    chk("rst_mem_we", bus.o_mem_we, 0);
    chk("rst_mem_addr", bus.o_mem_addr, 0);
    chk("rst_mem_wmask", bus.o_mem_wmask, 0);
    chk("rst_if_gnt", bus.o_if_gnt, 0);
    chk("rst_ls_gnt", bus.o_ls_gnt, 0);
    chk("rst_if_rvalid", bus.o_if_rvalid, 0);
    chk("rst_ls_rvalid", bus.o_ls_rvalid, 0);
    rst_n = 1'b1;
    tick();

    // IFU-only read
    bus.i_if_req = 1'b1;
    bus.i_if_addr = 64'h8000_0000;
    #1;
    chk("ifu_gnt", bus.o_if_gnt, 1);
    chk("ifu_no_ls_gnt", bus.o_ls_gnt, 0);
    chk("idle_no_mem_req", bus.o_mem_req, 0);
    tick();
    bus.i_if_req = 1'b0;
    bus.i_mem_gnt = 1'b1;
    #1;
    chk("ifu_mem_req", bus.o_mem_req, 1);
    chk("ifu_mem_addr", bus.o_mem_addr, 64'h8000_0000);
    chk("ifu_mem_we", bus.o_mem_we, 0);
    chk("ifu_no_regnt", bus.o_if_gnt, 0);
    tick();
    bus.i_mem_gnt = 1'b0;
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata = 64'hDEAD_BEEF_0000_0013;
    #1;
    chk("ifu_rvalid", bus.o_if_rvalid, 1);
    chk("ifu_rdata", bus.o_if_rdata, 64'h0000_0013);
    chk("ifu_no_ls_rvalid", bus.o_ls_rvalid, 0);
    tick();
    bus.i_mem_rvalid = 1'b0;
    #1;
    chk("ifu_rvalid_pulse", bus.o_if_rvalid, 0);
    chk("ifu_done_mem_req", bus.o_mem_req, 0);

    // LSU write with five stall cycles; a fetch queues up behind it
    bus.i_ls_req = 1'b1;
    bus.i_ls_we = 1'b1;
    bus.i_ls_addr = 64'h8000_0100;
    bus.i_ls_wdata = 64'h1122_3344_5566_7788;
    bus.i_ls_wmask = 8'h0F;
    #1;
    chk("lsw_gnt", bus.o_ls_gnt, 1);
    tick();
    bus.i_ls_req = 1'b0;
    bus.i_ls_we = 1'b0;
    bus.i_if_req = 1'b1;
    bus.i_if_addr = 64'h8000_0004;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_mem_req", bus.o_mem_req, 1);
      chk("stall_mem_addr", bus.o_mem_addr, 64'h8000_0100);
      chk("stall_mem_we", bus.o_mem_we, 1);
      chk("stall_mem_wmask", bus.o_mem_wmask, 8'h0F);
      chk("stall_mem_wdata", bus.o_mem_wdata, 64'h1122_3344_5566_7788);
      chk("stall_no_if_gnt", bus.o_if_gnt, 0);
      chk("stall_no_ls_gnt", bus.o_ls_gnt, 0);
      tick();
    end
    bus.i_mem_gnt = 1'b1;
    #1;
    chk("lsw_req_at_gnt", bus.o_mem_req, 1);
    tick();
    bus.i_mem_gnt = 1'b0;
    #1;
    chk("lsw_wait_no_rvalid", bus.o_ls_rvalid, 0);
    chk("lsw_wait_mem_req", bus.o_mem_req, 0);
    tick();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata = 64'h0123_4567_89AB_CDEF;
    #1;
    chk("lsw_ack", bus.o_ls_rvalid, 1);
    chk("lsw_ack_rdata", bus.o_ls_rdata, 64'h0123_4567_89AB_CDEF);
    chk("lsw_no_if_rvalid", bus.o_if_rvalid, 0);
    chk("wait_accept_if_gnt", bus.o_if_gnt, 1);
    tick();

    // gnt and rvalid together in REQ: grant taken, rvalid ignored
    bus.i_mem_rvalid = 1'b1;
    bus.i_if_req = 1'b0;
    bus.i_mem_gnt = 1'b1;
    #1;
    chk("both_if_rvalid", bus.o_if_rvalid, 0);
    chk("both_ls_rvalid", bus.o_ls_rvalid, 0);
    chk("ifu2_mem_addr", bus.o_mem_addr, 64'h8000_0004);
    chk("ifu2_mem_we", bus.o_mem_we, 0);
    chk("ifu2_mem_wmask", bus.o_mem_wmask, 0);
    tick();
    bus.i_mem_gnt = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    #1;
    chk("ifu2_wait_mem_req", bus.o_mem_req, 0);

    // Reset while in WAIT, late response after release
    rst_n = 1'b0;
    bus.i_ls_req = 1'b1;
    #1;
    chk("midrst_ls_gnt", bus.o_ls_gnt, 0);
    chk("midrst_mem_req", bus.o_mem_req, 0);
    chk("midrst_mem_addr", bus.o_mem_addr, 0);
    chk("midrst_if_rvalid", bus.o_if_rvalid, 0);
    tick();
    rst_n = 1'b1;
    bus.i_ls_req = 1'b0;
    #1;
    tick();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    chk("late_if_rvalid", bus.o_if_rvalid, 0);
    chk("late_ls_rvalid", bus.o_ls_rvalid, 0);
    chk("late_if_rdata", bus.o_if_rdata, 0);
    chk("late_mem_req", bus.o_mem_req, 0);
    tick();
    bus.i_mem_rvalid = 1'b0;
    #1;
    chk("late_idle_mem_req", bus.o_mem_req, 0);

    // LSU request withdrawn before it is granted
    bus.i_if_req = 1'b1;
    bus.i_if_addr = 64'h8000_0008;
    #1;
    chk("post_rst_if_gnt", bus.o_if_gnt, 1);
    tick();
    bus.i_if_req = 1'b0;
    bus.i_ls_req = 1'b1;
    bus.i_ls_we = 1'b0;
    bus.i_ls_addr = 64'h8000_0200;
    bus.i_mem_gnt = 1'b1;
    #1;
    chk("drop_no_ls_gnt_req", bus.o_ls_gnt, 0);
    tick();
    bus.i_ls_req = 1'b0;
    bus.i_mem_gnt = 1'b0;
    #1;
    tick();
    bus.i_mem_rvalid = 1'b1;
    bus.i_mem_rdata = 64'h0000_0000_0000_0073;
    #1;
    chk("drop_if_rvalid", bus.o_if_rvalid, 1);
    chk("drop_if_rdata", bus.o_if_rdata, 64'h73);
    chk("drop_no_ls_gnt", bus.o_ls_gnt, 0);
    chk("drop_no_if_gnt", bus.o_if_gnt, 0);
    tick();
    bus.i_mem_rvalid = 1'b0;
    #1;
    chk("drop_mem_req0", bus.o_mem_req, 0);
    tick();
    #1;
    chk("drop_mem_req1", bus.o_mem_req, 0);

    // Both requesters held: LSU x4 then IFU, repeating
    bus.i_if_req = 1'b1;
    bus.i_if_addr = 64'h8000_0010;
    bus.i_ls_req = 1'b1;
    bus.i_ls_we = 1'b0;
    bus.i_ls_addr = 64'h8000_0300;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("starve_ls_gnt", bus.o_ls_gnt, lsu_pat[i]);
      chk("starve_if_gnt", bus.o_if_gnt, !lsu_pat[i]);
      if (i > 0) begin
        chk("starve_ls_rvalid", bus.o_ls_rvalid, lsu_pat[i-1]);
      end
      tick();
      bus.i_mem_rvalid = 1'b0;
      bus.i_mem_gnt = 1'b1;
      #1;
      tick();
      bus.i_mem_gnt = 1'b0;
      bus.i_mem_rvalid = 1'b1;
      if (i == 9) begin
        bus.i_if_req = 1'b0;
        bus.i_ls_req = 1'b0;
      end
      #1;
    end
    chk("starve_last_if_rvalid", bus.o_if_rvalid, 1);
    chk("starve_last_no_if_gnt", bus.o_if_gnt, 0);
    chk("starve_last_no_ls_gnt", bus.o_ls_gnt, 0);
    tick();
    bus.i_mem_rvalid = 1'b0;
    #1;
    chk("starve_end_mem_req", bus.o_mem_req, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical memory port between the instruction fetch unit and the load/store unit.
- Accepts one request per cycle at an accept point, latches it, drives it to memory, waits for the response and routes it back to the owning requester.
- Priority: fixed LSU-over-IFU, with a starvation guard so fetch always makes progress.
- Sits between ifu/lsu and the memory access module of the core.

Parameters:
- CPU_WIDTH, 64, address and data width (matches `CPU_WIDTH in config.sv)
- STARVE_MAX, 4, consecutive LSU wins while the IFU waits before the IFU is forced to win; must be ≥1

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_if_req  in  1  IFU read request
- i_if_addr  in  CPU_WIDTH  IFU fetch address (pc)
- o_if_gnt  out  1  IFU request accepted (1-cycle pulse)
- o_if_rvalid  out  1  IFU response valid (1-cycle pulse)
- o_if_rdata  out  32  fetched instruction, low 32 bits of memory data
- i_ls_req  in  1  LSU request
- i_ls_we  in  1  LSU write enable
- i_ls_addr  in  CPU_WIDTH  LSU address
- i_ls_wdata  in  CPU_WIDTH  LSU write data
- i_ls_wmask  in  8  LSU byte write mask
- o_ls_gnt  out  1  LSU request accepted (1-cycle pulse)
- o_ls_rvalid  out  1  LSU response or write-ack valid (1-cycle pulse)
- o_ls_rdata  out  CPU_WIDTH  LSU read data
- o_mem_req  out  1  memory request
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  CPU_WIDTH  memory address
- o_mem_wdata  out  CPU_WIDTH  memory write data
- o_mem_wmask  out  8  memory byte mask
- i_mem_gnt  in  1  memory accepted request
- i_mem_rvalid  in  1  memory response / write-ack
- i_mem_rdata  in  CPU_WIDTH  memory read data

Behaviour:
- One clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: state = IDLE, owner = NONE, starve_cnt = 0, all latched request fields = 0, every output = 0.
- FSM states IDLE, REQ, WAIT:
  - IDLE is an accept point. If any request is present, select a winner, pulse its gnt in the same cycle, latch we/addr/wdata/wmask (IFU: we = 0, wmask = 0), then go to REQ.
  - REQ: o_mem_req = 1 and o_mem_* are driven from the latches (registered, stable until granted). When i_mem_gnt = 1, drop o_mem_req next cycle and go to WAIT.
  - WAIT: when i_mem_rvalid = 1, pulse o_if_rvalid or o_ls_rvalid for the owner in that cycle, with rdata passed combinationally.
    - o_if_rdata = i_mem_rdata[31:0]; the non-owner rvalid stays 0.
    - The same cycle is also an accept point: if a request is pending, grant it and go to REQ; otherwise go to IDLE.
- Selection at an accept point:
  - Only one requester: it wins.
  - Both requesting: the LSU wins unless starve_cnt == STARVE_MAX, in which case the IFU wins.
- starve_cnt:
  - Increments, saturating at STARVE_MAX, when the LSU wins while i_if_req = 1.
  - Clears to 0 whenever the IFU is granted.
  - Holds otherwise.
- Latency: gnt at cycle T, o_mem_req at T+1. With i_mem_gnt at T+1 and i_mem_rvalid at T+2, rvalid returns at T+2. Back-to-back throughput is one transaction per 2 cycles at best.
- Requesters hold req and payload stable until gnt. Dropping req before gnt is legal; no transaction results.
- Writes: memory returns i_mem_rvalid as an ack. o_ls_rdata is don't-care but is driven with i_mem_rdata.
- i_mem_gnt outside REQ and i_mem_rvalid outside WAIT are ignored; no state change, no rvalid pulse.
- i_mem_gnt and i_mem_rvalid high in the same REQ cycle: the grant is taken, and rvalid is ignored in that cycle.
- Reset asserted mid-transaction: the transaction is dropped and the FSM returns to IDLE. A late memory response after reset release is ignored (state ≠ WAIT).

Decomposition:
- mem_arb_pkg:
  - state enum (IDLE, REQ, WAIT)
  - owner enum (NONE, IFU, LSU)
  - request struct (we, addr, wdata, wmask)
- Sub-module arb_pick: combinational winner selection plus the saturating starve_cnt register. The FSM and latches stay in mem_arbiter.

Test Plan:
- IFU-only read, addr 0x8000_0000; memory gnt at T+1, rvalid at T+2 with rdata 0xDEAD_BEEF_0000_0013 -> o_if_gnt at T, o_if_rvalid at T+2, o_if_rdata = 0x0000_0013, o_ls_rvalid stays 0.
- LSU write, addr 0x8000_0100, wdata 0x1122_3344_5566_7788, wmask 0x0F -> o_mem_we = 1 and o_mem_wmask = 0x0F held through REQ; rvalid ack produces o_ls_rvalid = 1 for one cycle.
- Both requesters continuously asserted, STARVE_MAX = 4 -> grant sequence LSU, LSU, LSU, LSU, IFU, then repeating; starve_cnt returns to 0 after each IFU grant.
- Memory holds i_mem_gnt low for 5 cycles in REQ -> o_mem_req and o_mem_addr stay constant for all 5 cycles; no second gnt to either requester.
- i_rst_n pulled low in WAIT, and i_mem_rvalid arrives 1 cycle after release -> all outputs 0 during reset; no rvalid pulse; FSM in IDLE.
- Stray i_mem_rvalid in IDLE, and i_ls_req dropped before being granted -> no output pulses, no memory request issued.
